psg_stereo_mixer: RTL

- Parametrised PSG channel mixer; successor to the fixed 3-channel mono/ABC/ACB audio summing in the core top level.
- Snapshots N unsigned tone channels on a sample strobe and accumulates them sequentially into left/right sums, one channel per clock.
- Channel routing comes from a mode selector or from per-channel pan masks.
- Sits between the sound generator and AUDIO_L/AUDIO_R, in the clk_sys domain.

---
 rtl/psg_stereo_mixer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/psg_stereo_mixer.sv
// Sequential N-channel PSG mixer: snapshots channels on ce_sample, sums one channel per clock into L/R.
// Optional PSG_MIXER_SIGNED_OUT_EN inverts the output MSB (offset-binary -> two's complement).
//
// state | meaning
// IDLE  | waiting for ce_sample; a strobe latches the snapshot and masks
// ACC   | adding channel idx into acc_l/acc_r, one channel per clock
// OUT   | publishing the scaled sums, pulsing out_valid on the next cycle
module psg_stereo_mixer #(
    parameter int CH_NUM = 3,
    parameter int IN_W   = 12,
    parameter int OUT_W  = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ce_sample,
    input  logic [CH_NUM*IN_W-1:0]   ch_in,
    input  logic [1:0]               mode,
    input  logic [CH_NUM-1:0]        pan_l,
    input  logic [CH_NUM-1:0]        pan_r,
    input  logic                     ovr_clr,
    output logic [OUT_W-1:0]         audio_l,
    output logic [OUT_W-1:0]         audio_r,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int SW    = IN_W + $clog2(CH_NUM);
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);

    // Fixed routings only cover channels 0..2; wider builds see zeros above that.
    localparam logic [15:0] ABC_L = 16'h0003;
    localparam logic [15:0] ABC_R = 16'h0006;
    localparam logic [15:0] ACB_L = 16'h0005;
    localparam logic [15:0] ACB_R = 16'h0006;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                   state, state_nxt;
    logic [CH_NUM*IN_W-1:0]   snap;
    logic [CH_NUM-1:0]        mask_l, mask_r;
    logic [CH_NUM-1:0]        eff_l, eff_r;
    logic [IDX_W-1:0]         idx;
    logic [SW-1:0]            acc_l, acc_r;
    logic [IN_W-1:0]          cur;
    logic [OUT_W-1:0]         scaled_l, scaled_r;

    always_comb begin
        eff_l = '1;
        eff_r = '1;
        case (mode)
            2'd1: begin
                eff_l = ABC_L[CH_NUM-1:0];
                eff_r = ABC_R[CH_NUM-1:0];
            end
            2'd2: begin
                eff_l = ACB_L[CH_NUM-1:0];
                eff_r = ACB_R[CH_NUM-1:0];
            end
            2'd3: begin
                eff_l = pan_l;
                eff_r = pan_r;
            end
            default: begin
                eff_l = '1;
                eff_r = '1;
            end
        endcase
    end

    assign cur  = snap[idx*IN_W +: IN_W];
    assign busy = (state != IDLE);

    generate
        if (OUT_W > SW) begin : g_shift
            assign scaled_l = {acc_l, {(OUT_W-SW){1'b0}}};
            assign scaled_r = {acc_r, {(OUT_W-SW){1'b0}}};
        end else if (OUT_W == SW) begin : g_equal
            assign scaled_l = acc_l;
            assign scaled_r = acc_r;
        end else begin : g_trunc
            assign scaled_l = acc_l[SW-1 -: OUT_W];
            assign scaled_r = acc_r[SW-1 -: OUT_W];
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ce_sample) state_nxt = ACC;
            ACC:     if (idx == IDX_LAST) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            snap      <= '0;
            mask_l    <= '0;
            mask_r    <= '0;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            audio_l   <= '0;
            audio_r   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= (state == OUT);
            case (state)
                IDLE: begin
                    if (ce_sample) begin
                        snap   <= ch_in;
                        mask_l <= eff_l;
                        mask_r <= eff_r;
                        acc_l  <= '0;
                        acc_r  <= '0;
                        idx    <= '0;
                    end
                end
                ACC: begin
                    if (mask_l[idx]) acc_l <= acc_l + SW'(cur);
                    if (mask_r[idx]) acc_r <= acc_r + SW'(cur);
                    idx <= idx + 1'b1;
                end
                OUT: begin
                    audio_l <= scaled_l;
                    audio_r <= scaled_r;
`ifdef PSG_MIXER_SIGNED_OUT_EN
                    audio_l[OUT_W-1] <= ~scaled_l[OUT_W-1];
                    audio_r[OUT_W-1] <= ~scaled_r[OUT_W-1];
`endif
                end
                default: ;
            endcase
            // A late strobe outranks a clear on the same edge.
            if (ce_sample && (state != IDLE)) overrun <= 1'b1;
            else if (ovr_clr)                 overrun <= 1'b0;
        end
    end

endmodule
